// File: rtl/reg_file_reader_if.sv
// -----------------------------------------------------------------------------
// reg_file_reader_if
//   Request/response bundle for reg_file_reader.
//
//   Request channel (master -> slave, valid/ready):
//     req_valid  burst read request present
//     req_ready  slave accepts a request
//     req_addr   start register address (5 bits)
//     req_len    burst length minus one (0 = 1 word, 31 = 32 words)
//
//   Response channel (slave -> master, valid/ready):
//     rsp_valid  rsp_data/rsp_addr/rsp_last valid
//     rsp_ready  master accepts the current word
//     rsp_data   read register value (WD bits)
//     rsp_addr   address of the word on rsp_data
//     rsp_last   current word is the final word of the burst
//
//   Modports: master = requester/consumer, slave = reg_file_reader.
// -----------------------------------------------------------------------------
interface reg_file_reader_if #(
   parameter int WD = 32
);
   logic          req_valid;
   logic          req_ready;
   logic [4:0]    req_addr;
   logic [4:0]    req_len;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [WD-1:0] rsp_data;
   logic [4:0]    rsp_addr;
   logic          rsp_last;

   modport master (
      output req_valid, req_addr, req_len, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_last
   );

   modport slave (
      input  req_valid, req_addr, req_len, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_last
   );
endinterface

// File: rtl/reg_file_reader.sv
// -----------------------------------------------------------------------------
// reg_file_reader
//   Burst reader over a flattened 32-entry register file. A request gives a
//   start address and a length; the block then streams one register per
//   accepted response beat, incrementing the address modulo 32, and flags
//   the final word with rsp_last.
//
// Ports:
//   clk     single clock, all state on the rising edge
//   reset   asynchronous, active-low reset
//   regs_i  flattened register contents, register i at [i*WD +: WD]
//   bus     reg_file_reader_if.slave (request and response channels)
//   busy    burst in progress
//
// Parameters:
//   WD      register width in bits (default 32)
//   NREG    number of registers, fixed at 32 (5-bit address)
//
// Build option:
//   REG0_ZERO_EN  when defined, any word read from address 0 returns zero
//                 regardless of regs_i; when undefined, address 0 is an
//                 ordinary register.
// -----------------------------------------------------------------------------
module reg_file_reader #(
   parameter int WD   = 32,
   parameter int NREG = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREG*WD-1:0]   regs_i,
   reg_file_reader_if.slave     bus,
   output logic                 busy
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      SEND = 2'b01
   } state_t;

   state_t        state_q, state_d;
   logic [4:0]    addr_q,  addr_d;
   logic [4:0]    cnt_q,   cnt_d;
   logic [WD-1:0] data_q,  data_d;
   logic          last_q,  last_d;

   logic [4:0]    rd_idx;
   logic [WD-1:0] rd_word;

   // Read port address: the request address when a burst may start, the next
   // sequential address (wrapping naturally in 5 bits) while streaming.
   always_comb begin
      rd_idx = bus.req_addr;
      if (state_q == SEND) begin
         rd_idx = addr_q + 5'd1;
      end
   end

`ifdef REG0_ZERO_EN
   assign rd_word = (rd_idx == 5'd0) ? '0 : regs_i[rd_idx*WD +: WD];
`else
   assign rd_word = regs_i[rd_idx*WD +: WD];
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_q <= '0;
         cnt_q  <= '0;
         data_q <= '0;
         last_q <= 1'b0;
      end else begin
         addr_q <= addr_d;
         cnt_q  <= cnt_d;
         data_q <= data_d;
         last_q <= last_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      cnt_d         = cnt_q;
      data_d        = data_q;
      last_d        = last_q;
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      busy          = 1'b0;

      case (state_q)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               addr_d  = bus.req_addr;
               data_d  = rd_word;
               cnt_d   = bus.req_len;
               last_d  = (bus.req_len == 5'd0);
               state_d = SEND;
            end
         end

         SEND: begin
            bus.rsp_valid = 1'b1;
            busy          = 1'b1;
            // Without a handshake the held word is left untouched, so
            // changes on regs_i cannot disturb a stalled beat.
            if (bus.rsp_ready) begin
               if (last_q) begin
                  last_d  = 1'b0;
                  state_d = IDLE;
               end else begin
                  addr_d = addr_q + 5'd1;
                  data_d = rd_word;
                  cnt_d  = cnt_q - 5'd1;
                  last_d = (cnt_q == 5'd1);
               end
            end
         end

         default: begin
            state_d = IDLE;
            last_d  = 1'b0;
         end
      endcase
   end

   assign bus.rsp_addr = addr_q;
   assign bus.rsp_data = data_q;
   assign bus.rsp_last = last_q;

endmodule

// File: doc/reg_file_reader.md
REG_FILE_READER -- requirements
Module: reg_file_reader

Interface
REQ-001 SHALL have parameter WD, default 32, data width of one register in bits.
REQ-002 SHALL have parameter NREG, fixed 32, number of registers; address width 5 bits.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port regs_i  input  NREG*WD  flattened register contents, register i at bits [i*WD +: WD].
REQ-006 SHALL have port req_valid  input  1  burst read request present.
REQ-007 SHALL have port req_ready  output  1  block accepts a request.
REQ-008 SHALL have port req_addr  input  5  start register address.
REQ-009 SHALL have port req_len  input  5  burst length minus one (0 = 1 word, 31 = 32 words).
REQ-010 SHALL have port rsp_valid  output  1  rsp_data/rsp_addr/rsp_last valid.
REQ-011 SHALL have port rsp_ready  input  1  consumer accepts the current word.
REQ-012 SHALL have port rsp_data  output  WD  read register value.
REQ-013 SHALL have port rsp_addr  output  5  address of the word on rsp_data.
REQ-014 SHALL have port rsp_last  output  1  current word is the final word of the burst.
REQ-015 SHALL have port busy  output  1  burst in progress (state SEND).

Function
REQ-016 SHALL implement a two-state FSM: IDLE, SEND.
REQ-017 IDLE: req_ready=1, rsp_valid=0; request accepted when req_valid=1 and req_ready=1.
REQ-018 On acceptance edge: capture rsp_addr=req_addr, rsp_data=regs_i word at req_addr (sampled that cycle), remaining count=req_len, rsp_last=(req_len==0); go to SEND; rsp_valid=1 the following cycle (1-cycle latency).
REQ-019 SEND: req_ready=0, busy=1, rsp_valid=1; requests ignored.
REQ-020 While rsp_valid=1 and rsp_ready=0: rsp_data, rsp_addr, rsp_last SHALL hold stable, even if regs_i changes.
REQ-021 Handshake (rsp_valid & rsp_ready) with rsp_last=0: rsp_addr increments by 1 modulo 32 (31 wraps to 0), rsp_data resampled from regs_i at the new address in the same edge, count decrements, rsp_last=1 when new count==0; rsp_valid stays 1 (one word per cycle with rsp_ready held high).
REQ-022 Handshake with rsp_last=1: go to IDLE; rsp_valid=0 and req_ready=1 the next cycle; no back-to-back acceptance in the final SEND cycle.
REQ-023 Burst of req_len=L SHALL deliver exactly L+1 words, exactly one with rsp_last=1.
REQ-024 Unused FSM encodings SHALL recover to IDLE.

Reset
REQ-025 reset=0 SHALL asynchronously force IDLE: req_ready=1, rsp_valid=0, busy=0, rsp_last=0, rsp_addr=0, rsp_data=0, count=0.
REQ-026 Reset mid-burst SHALL abort the burst; no further words delivered after reset release until a new request.
REQ-027 First request SHALL be accepted no earlier than the first rising edge after reset deasserts.

Configuration
REQ-028 Macro REG0_ZERO_EN defined: any word read from address 0 SHALL return all zeros regardless of regs_i; undefined: address 0 returns regs_i register 0 like any other.

Verification
REQ-029 Single read: regs_i[5]=32'hDEADBEEF, req_addr=5, req_len=0, rsp_ready=1 -> next cycle rsp_valid=1, rsp_data=32'hDEADBEEF, rsp_addr=5, rsp_last=1; IDLE one cycle later.
REQ-030 Wrap burst: req_addr=30, req_len=3, regs_i[i]=i -> words 30,31,0,1 on consecutive cycles, rsp_last only with addr 1.
REQ-031 Backpressure: req_len=1, rsp_ready=0 for 4 cycles, regs_i[addr] changed meanwhile -> rsp_data/rsp_addr held unchanged; rsp_ready=1 -> second word next cycle.
REQ-032 Reset mid-burst: req_len=31, reset=0 after 3 words -> rsp_valid=0, req_ready=1 immediately; no words after release.
REQ-033 Request during SEND: req_valid=1 throughout burst -> req_ready=0 until one cycle after last handshake, then accepted.
REQ-034 REG0_ZERO_EN: regs_i[0]=32'hFFFFFFFF, req_addr=0, req_len=0 -> rsp_data=0 with macro, 32'hFFFFFFFF without.
